adder_bist: RTL and testbench
=============================

ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameter: WIDTH, default 6, operand width of the adder under test.
REQ-002 Parameter: SETTLE, default 1, cycles (>=0) held on the adder inputs before the result is sampled.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle run request.
REQ-006 abort  input  1  cancels a run in progress.
REQ-007 dut_x, dut_y  output  WIDTH  operands driven to the adder under test.
REQ-008 dut_s  input  WIDTH, dut_cout  input  1  adder result.
REQ-009 busy  output  1  run in progress.
REQ-010 done  output  1  run complete, held.
REQ-011 pass  output  1  done with zero errors.
REQ-012 err_cnt  output  32  mismatch count, saturating.
REQ-013 vec_idx  output  2*WIDTH  current vector index, {x,y}.
REQ-014 first_err_valid  output  1, first_err_idx  output  32, first_err_got  output  WIDTH+1  first-mismatch log.

Function
REQ-015 States SHALL be IDLE, APPLY, CHECK, DONE.
REQ-016 IDLE, start=1: vec_idx<=0, err_cnt<=0, done<=0, pass<=0, log cleared, settle counter<=SETTLE, go APPLY.
REQ-017 APPLY: dut_x=vec_idx[2W-1:W], dut_y=vec_idx[W-1:0]; counter decrements; at counter==0 go CHECK (APPLY lasts SETTLE+1 cycles).
REQ-018 CHECK: expected = dut_x + dut_y in WIDTH+1 bits; mismatch when {dut_cout,dut_s} differs; err_cnt+1 on mismatch, saturating at 2^32-1.
REQ-019 CHECK, vec_idx = 2^(2W)-1: go DONE; otherwise vec_idx+1, reload counter, go APPLY; no wrap-around.
REQ-020 Each vector SHALL take exactly SETTLE+2 cycles; no vector skipped or repeated.
REQ-021 DONE: done=1, pass=(err_cnt==0), busy=0; held until start, abort or reset.
REQ-022 start in DONE SHALL restart as in REQ-016; start in APPLY/CHECK SHALL be ignored.
REQ-023 abort in APPLY/CHECK/DONE: next state IDLE, busy=0, done=0, pass=0; err_cnt and vec_idx keep their values; abort has priority over start.
REQ-024 busy=1 exactly in APPLY and CHECK; dut_x/dut_y SHALL be 0 in IDLE and DONE.

Reset
REQ-025 rst_n low SHALL force asynchronously: state IDLE, every output 0, counters 0, log cleared.
REQ-026 Reset mid-run SHALL abandon the run; no done pulse is produced.

Configuration
REQ-027 Macro ADDER_BIST_ERRLOG_EN defined: on the first mismatch of a run, capture first_err_idx = vec_idx+1 (1-based) and first_err_got = {dut_cout,dut_s}, and set first_err_valid; later mismatches SHALL not overwrite.
REQ-028 Macro undefined: log ports present, constant 0, no log registers synthesized.

Structure
REQ-029 Shared package adder_pkg: state enum typedef, default WIDTH constant, err_cnt width constant (32).
REQ-030 One sub-module adder_bist_gen: vector index counter and settle counter with load/step/last outputs; FSM and checker stay in adder_bist.

Verification (WIDTH=6, SETTLE=1, log enabled)
REQ-031 Correct adder, start pulse -> done rises on the 12289th rising edge after start was sampled; pass=1, err_cnt=0, first_err_valid=0.
REQ-032 Adder with dut_cout stuck at 0 -> err_cnt=2016, pass=0, first_err_idx=128 (x=1, y=63), first_err_got=7'b0000000.
REQ-033 Adder with dut_s[0] stuck at 1 -> err_cnt=2048, first_err_idx=1, first_err_got=7'b0000001.
REQ-034 rst_n low 500 cycles after start -> all outputs 0 immediately, no done; fresh start then completes per REQ-031.
REQ-035 abort 100 cycles after start -> busy=0, done=0 next cycle; start during a run is ignored (vec_idx keeps its progression).
REQ-036 start while in DONE -> done=0 next cycle, err_cnt=0, full rerun completes per REQ-031.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the adder built-in self-test.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int DEF_WIDTH = 6;
  localparam int ERR_W     = 32;

endpackage

// File: rtl/adder_bist_gen.sv
// Vector index and settle counter for the adder BIST; the FSM in adder_bist
// drives the clear/step/load/decrement controls.
module adder_bist_gen
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               idx_clr,
  input  logic               idx_inc,
  input  logic               cnt_load,
  input  logic               cnt_dec,
  output logic [2*WIDTH-1:0] vec_idx,
  output logic               idx_last,
  output logic               cnt_zero
);

  localparam int IW = 2 * WIDTH;
  // SETTLE may be 0, which still needs a one-bit counter.
  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    idx_d = idx_q;
    if (idx_clr) begin
      idx_d = '0;
    end else if (idx_inc) begin
      idx_d = idx_q + IW'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_load) begin
      cnt_d = CW'(SETTLE);
    end else if (cnt_dec) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  assign vec_idx  = idx_q;
  assign idx_last = &idx_q;
  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/adder_bist.sv
// Exhaustive self-test of a WIDTH-bit adder: sweeps every {x,y} pair, counts
// mismatches. Define ADDER_BIST_ERRLOG_EN to keep a first-mismatch log.
module adder_bist
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [WIDTH-1:0]   dut_x,
  output logic [WIDTH-1:0]   dut_y,
  input  logic [WIDTH-1:0]   dut_s,
  input  logic               dut_cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [2*WIDTH-1:0] vec_idx,
  output logic               first_err_valid,
  output logic [ERR_W-1:0]   first_err_idx,
  output logic [WIDTH:0]     first_err_got
);

  state_e state_q, state_d;

  logic run_init, idx_inc, cnt_load, cnt_dec, chk_en;
  logic idx_last, cnt_zero;
  logic [WIDTH:0] exp_sum, got_sum;
  logic mismatch;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic done_q, done_d, pass_q, pass_d;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  adder_bist_gen #(
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE)
  ) u_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx_clr  (run_init),
    .idx_inc  (idx_inc),
    .cnt_load (cnt_load),
    .cnt_dec  (cnt_dec),
    .vec_idx  (vec_idx),
    .idx_last (idx_last),
    .cnt_zero (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (run_init) state_d = ST_APPLY;
      ST_APPLY: begin
        if (abort)         state_d = ST_IDLE;
        else if (cnt_zero) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)         state_d = ST_IDLE;
        else if (idx_last) state_d = ST_DONE;
        else               state_d = ST_APPLY;
      end
      ST_DONE: begin
        if (abort)         state_d = ST_IDLE;
        else if (run_init) state_d = ST_APPLY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Abort outranks start everywhere, and freezes counters on the cycle it lands.
  always_comb begin
    run_init = 1'b0;
    idx_inc  = 1'b0;
    cnt_dec  = 1'b0;
    chk_en   = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      ST_IDLE:  run_init = start & ~abort;
      ST_APPLY: begin
        busy    = 1'b1;
        cnt_dec = ~abort & ~cnt_zero;
      end
      ST_CHECK: begin
        busy    = 1'b1;
        chk_en  = ~abort;
        idx_inc = ~abort & ~idx_last;
      end
      ST_DONE:  run_init = start & ~abort;
      default:  ;
    endcase
  end

  assign cnt_load = run_init | idx_inc;

  always_comb begin
    dut_x = '0;
    dut_y = '0;
    if (busy) begin
      dut_x = vec_idx[2*WIDTH-1:WIDTH];
      dut_y = vec_idx[WIDTH-1:0];
    end
  end

  always_comb begin
    exp_sum  = (WIDTH+1)'(dut_x) + (WIDTH+1)'(dut_y);
    got_sum  = {dut_cout, dut_s};
    mismatch = chk_en && (got_sum != exp_sum);
  end

  // done/pass appear on the first edge spent in DONE, once the final count is settled.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (run_init) begin
      err_cnt_d = '0;
    end else if (mismatch) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
    done_d = (state_q == ST_DONE) & ~abort & ~start;
    pass_d = done_d & (err_cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign done    = done_q;
  assign pass    = pass_q;

`ifdef ADDER_BIST_ERRLOG_EN
  logic             log_valid_q, log_valid_d;
  logic [ERR_W-1:0] log_idx_q, log_idx_d;
  logic [WIDTH:0]   log_got_q, log_got_d;

  always_comb begin
    log_valid_d = log_valid_q;
    log_idx_d   = log_idx_q;
    log_got_d   = log_got_q;
    if (run_init) begin
      log_valid_d = 1'b0;
      log_idx_d   = '0;
      log_got_d   = '0;
    end else if (mismatch && !log_valid_q) begin
      log_valid_d = 1'b1;
      log_idx_d   = ERR_W'(vec_idx) + ERR_W'(1);
      log_got_d   = got_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_valid_q <= 1'b0;
      log_idx_q   <= '0;
      log_got_q   <= '0;
    end else begin
      log_valid_q <= log_valid_d;
      log_idx_q   <= log_idx_d;
      log_got_q   <= log_got_d;
    end
  end

  assign first_err_valid = log_valid_q;
  assign first_err_idx   = log_idx_q;
  assign first_err_got   = log_got_q;
`else
  assign first_err_valid = 1'b0;
  assign first_err_idx   = '0;
  assign first_err_got   = '0;
`endif

endmodule

// File: tb/tb_adder_bist.sv
// Directed bench for adder_bist (WIDTH=6, SETTLE=1) with a fault-injectable adder.
module tb_adder_bist;

  localparam int WIDTH  = 6;
  localparam int SETTLE = 1;
  localparam int RUN_EDGES = 12289;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [WIDTH-1:0]   dut_x, dut_y, dut_s;
  logic               dut_cout;
  logic               busy, done, pass;
  logic [31:0]        err_cnt;
  logic [2*WIDTH-1:0] vec_idx;
  logic               first_err_valid;
  logic [31:0]        first_err_idx;
  logic [WIDTH:0]     first_err_got;

  int fault = 0;
  int vecs = 0;
  int miscompares = 0;

  logic [WIDTH:0] sum_raw;
  assign sum_raw  = {1'b0, dut_x} + {1'b0, dut_y};
  assign dut_cout = (fault == 1) ? 1'b0 : sum_raw[WIDTH];
  assign dut_s    = (fault == 2) ? (sum_raw[WIDTH-1:0] | 6'd1) : sum_raw[WIDTH-1:0];

  always #5 clk = ~clk;

  adder_bist #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .dut_x           (dut_x),
    .dut_y           (dut_y),
    .dut_s           (dut_s),
    .dut_cout        (dut_cout),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_cnt         (err_cnt),
    .vec_idx         (vec_idx),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .first_err_got   (first_err_got)
  );

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    for (int n = 1; n <= 13000; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({busy, done, pass, first_err_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, first_err_valid});
    end
    vecs++;
    if ({err_cnt, vec_idx, dut_x, dut_y} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: err_cnt=%0d vec_idx=%0d x=%0d y=%0d expected all 0",
               err_cnt, vec_idx, dut_x, dut_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_good_adder();
    int edges;
    fault = 0;
    pulse_start();
    wait_done(edges);
    vecs++;
    if (edges !== RUN_EDGES) begin
      miscompares++;
      $display("FAIL good_latency: got %0d edges expected %0d", edges, RUN_EDGES);
    end
    vecs++;
    if ({pass, busy, err_cnt, first_err_valid} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL good_result: pass=%b busy=%b err_cnt=%0d log_valid=%b expected 1 0 0 0",
               pass, busy, err_cnt, first_err_valid);
    end
  endtask

  task automatic test_restart_from_done();
    int edges;
    fault = 0;
    pulse_start();
    vecs++;
    if ({done, busy, err_cnt, vec_idx} !== {1'b0, 1'b1, 32'd0, 12'd0}) begin
      miscompares++;
      $display("FAIL restart_clear: done=%b busy=%b err_cnt=%0d vec_idx=%0d expected 0 1 0 0",
               done, busy, err_cnt, vec_idx);
    end
    wait_done(edges);
    vecs++;
    if (edges !== RUN_EDGES || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_run: edges=%0d pass=%b expected %0d 1", edges, pass, RUN_EDGES);
    end
  endtask

  task automatic test_fault(input int f, input logic [31:0] exp_cnt,
                            input logic [31:0] exp_idx, input logic [WIDTH:0] exp_got);
    int edges;
    logic        e_valid;
    logic [31:0] e_idx;
    logic [WIDTH:0] e_got;
`ifdef ADDER_BIST_ERRLOG_EN
    e_valid = 1'b1;
    e_idx   = exp_idx;
    e_got   = exp_got;
`else
    e_valid = 1'b0;
    e_idx   = '0;
    e_got   = '0;
`endif
    fault = f;
    pulse_start();
    wait_done(edges);
    vecs++;
    if (edges !== RUN_EDGES || err_cnt !== exp_cnt || pass !== 1'b0) begin
      miscompares++;
      $display("FAIL fault%0d_count: edges=%0d err_cnt=%0d pass=%b expected %0d %0d 0",
               f, edges, err_cnt, pass, RUN_EDGES, exp_cnt);
    end
    vecs++;
    if ({first_err_valid, first_err_idx, first_err_got} !== {e_valid, e_idx, e_got}) begin
      miscompares++;
      $display("FAIL fault%0d_log: valid=%b idx=%0d got=%b expected %b %0d %b",
               f, first_err_valid, first_err_idx, first_err_got, e_valid, e_idx, e_got);
    end
    fault = 0;
  endtask

  task automatic test_abort();
    fault = 0;
    pulse_start();
    repeat (49) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    vecs++;
    if ({busy, vec_idx, dut_x, dut_y} !== {1'b1, 12'd16, 6'd0, 6'd16}) begin
      miscompares++;
      $display("FAIL ignore_start: busy=%b vec_idx=%0d x=%0d y=%0d expected 1 16 0 16",
               busy, vec_idx, dut_x, dut_y);
    end
    repeat (49) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    vecs++;
    if ({busy, done, pass, vec_idx, err_cnt, dut_y} !== {3'b000, 12'd33, 32'd0, 6'd0}) begin
      miscompares++;
      $display("FAIL abort: busy=%b done=%b pass=%b vec_idx=%0d err_cnt=%0d y=%0d expected 0 0 0 33 0 0",
               busy, done, pass, vec_idx, err_cnt, dut_y);
    end
    repeat (5) @(posedge clk);
    #1;
    vecs++;
    if ({busy, done, vec_idx} !== {2'b00, 12'd33}) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b done=%b vec_idx=%0d expected 0 0 33", busy, done, vec_idx);
    end
  endtask

  task automatic test_reset_mid_run();
    int edges;
    fault = 1;
    pulse_start();
    repeat (500) @(posedge clk);
    #1;
    vecs++;
    if (err_cnt !== 32'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: err_cnt=%0d busy=%b expected 1 1", err_cnt, busy);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({busy, done, pass, first_err_valid, err_cnt, vec_idx, dut_x, dut_y, first_err_idx, first_err_got} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b done=%b err_cnt=%0d vec_idx=%0d log_valid=%b expected all 0",
               busy, done, err_cnt, vec_idx, first_err_valid);
    end
    fault = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    vecs++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
    pulse_start();
    wait_done(edges);
    vecs++;
    if (edges !== RUN_EDGES || pass !== 1'b1 || err_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL post_reset_run: edges=%0d pass=%b err_cnt=%0d expected %0d 1 0",
               edges, pass, err_cnt, RUN_EDGES);
    end
  endtask

  initial begin
    test_reset();
    test_good_adder();
    test_restart_from_done();
    test_fault(1, 32'd2016, 32'd128, 7'b0000000);
    test_fault(2, 32'd2048, 32'd1, 7'b0000001);
    test_abort();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
